dwt2d_tile_ctrl: RTL and testbench
==================================

DWT2D_TILE_CTRL -- requirements
Module: dwt2d_tile_ctrl

Interface
REQ-001 Parameter LAT, default 1, SHALL equal the 1-D core latency in cycles from wt_in to wt_out (legal range 1..4).
REQ-002 clk  input  1  sole clock, all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  an input row is present on in_row.
REQ-005 in_ready  output  1  controller accepts an input row this cycle.
REQ-006 in_row  input  64  one tile row, 8 pixels, pixel k in bits [8k+7:8k].
REQ-007 wt_in  output  64  row/column vector driven to the external 1-D wavelet core.
REQ-008 wt_out  input  64  core result, valid LAT cycles after the matching wt_in.
REQ-009 out_valid  output  1  a result row is present on out_row.
REQ-010 out_ready  input  1  downstream accepts out_row this cycle.
REQ-011 out_row  output  64  one transformed tile row, same packing as in_row.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 tile_done  output  1  single-cycle pulse after the last output row is accepted.

Function
REQ-014 Storage SHALL be an 8x8 byte tile buffer buf[r][c], where r is the row and c is the pixel.
REQ-015 FSM states SHALL be IDLE, LOAD, ROW, COL and OUT, with a 3-bit index counter and a LAT+8-bounded cycle counter.
REQ-016 IDLE SHALL go to LOAD on the first cycle out of reset, with in_ready=1 from that cycle.
REQ-017 In LOAD, in_ready SHALL be 1; each in_valid&in_ready SHALL write buf[idx] and increment idx; the 8th accepted row SHALL switch to ROW with idx reset to 0.
REQ-018 in_ready SHALL be 0 in ROW, COL and OUT; in_row SHALL then be ignored.
REQ-019 ROW SHALL last exactly 8+LAT cycles: in phase cycle t (0..7) wt_in=buf[t]; in phase cycle t+LAT, wt_out SHALL be written to buf[t].
REQ-020 COL SHALL last exactly 8+LAT cycles: in phase cycle t, wt_in byte k = buf[k][t]; in phase cycle t+LAT, byte k of wt_out SHALL be written to buf[k][t] for k=0..7.
REQ-021 Write-back SHALL never corrupt a vector not yet issued: in ROW, row t is written only after row t has been issued; in COL, column t likewise.
REQ-022 wt_in SHALL be 0 outside issue cycles (t>=8, or IDLE, LOAD, OUT).
REQ-023 ROW SHALL go to COL, and COL to OUT, with no idle cycle between them.
REQ-024 In OUT, out_valid=1 and out_row=buf[idx]; idx SHALL advance only on out_valid&out_ready.
REQ-025 out_row SHALL remain stable while out_valid&!out_ready.
REQ-026 On the 8th OUT handshake, tile_done SHALL pulse for 1 cycle and the FSM SHALL go to LOAD with idx=0, so the next tile may start the following cycle.
REQ-027 out_valid SHALL be 0 outside OUT.
REQ-028 Minimum tile period with no stalls SHALL be 8 + 2(8+LAT) + 8 cycles, i.e. 34 cycles at LAT=1.
REQ-029 No arithmetic SHALL be performed on pixel data; the controller only routes, transposes and stores bytes unmodified.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, idx=0, cycle counter=0, in_ready=0, out_valid=0, tile_done=0, busy=0 and wt_in=0.
REQ-031 Buffer contents need not be reset.
REQ-032 Reset asserted mid-tile SHALL discard the tile; after release the FSM SHALL restart in LOAD, and core results still in flight SHALL be ignored.

Verification
REQ-033 Identity core model (wt_out = wt_in delayed LAT), rows 0x0706050403020100 + r*0x0808080808080808 -> 8 output rows bit-identical to the input, tile_done exactly 34 cycles after the first accepted row at LAT=1.
REQ-034 Byte-reverse core model, input buf[r][c]=8r+c -> out_row r byte c = 8(7-r)+(7-c), which confirms both the row pass and the transposed column pass.
REQ-035 out_ready held low for 5 cycles on row 3 -> out_row stays at row 3, no row is lost or duplicated, and tile_done is delayed by 5 cycles.
REQ-036 in_valid held high throughout two tiles -> exactly 8 rows are accepted per tile, in_ready=0 during ROW/COL/OUT, and the second tile output is correct.
REQ-037 rst_n pulsed low during COL cycle 4 -> all outputs are 0 within the same cycle; a subsequent full tile is correct with no stale data.
REQ-038 Run the identity and byte-reverse tests at LAT=1 and LAT=3 -> the ROW and COL phases last 9 and 11 cycles respectively, and the outputs are correct at both settings.

Source files
------------

// File: rtl/dwt2d_tile_ctrl.sv
// dwt2d_tile_ctrl: 8x8 byte tile sequencer for a separable 2-D wavelet built on an
// external 1-D core. Loads 8 rows, runs a row pass and a transposed column pass
// through the core, then streams the 8 result rows out.
// Latency: last input row accepted -> first output row = 2*(8+LAT)+1 cycles; tile period 8+2*(8+LAT)+8.
// Backpressure: in_ready only in LOAD; out_row holds while out_valid & !out_ready.
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_row (row input);
//        wt_in/wt_out (1-D core, result LAT cycles after issue);
//        out_valid/out_ready/out_row (row output); busy (not IDLE); tile_done (1-cycle pulse).
module dwt2d_tile_ctrl #(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_row,
  output logic [63:0] wt_in,
  input  logic [63:0] wt_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_row,
  output logic        busy,
  output logic        tile_done
);

  typedef enum logic [2:0] {IDLE, LOAD, ROW, COL, OUT} state_t;

  localparam logic [3:0] LAT_C  = 4'(LAT);
  localparam logic [3:0] LAST_C = 4'(LAT + 7);  // final cycle of a ROW/COL phase

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  cyc_q, cyc_d;
  logic        done_q, done_d;
  logic [63:0] tile_buf [8];
  logic        load_we, row_we, col_we;
  logic [2:0]  wb_idx;

  // Row/column that the core result arriving this cycle belongs to.
  assign wb_idx    = 3'(cyc_q - LAT_C);
  assign tile_done = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      cyc_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cyc_d     = cyc_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_row   = 64'd0;
    wt_in     = 64'd0;
    busy      = (state_q != IDLE);
    load_we   = 1'b0;
    row_we    = 1'b0;
    col_we    = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        idx_d   = 3'd0;
        cyc_d   = 4'd0;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load_we = 1'b1;
          idx_d   = idx_q + 3'd1;  // wraps to 0 after the 8th row
          if (idx_q == 3'd7) begin
            state_d = ROW;
            cyc_d   = 4'd0;
          end
        end
      end
      ROW, COL: begin
        // Issue vectors in cycles 0..7; results for vector t land at t+LAT,
        // always after vector t itself has been read out.
        if (cyc_q < 4'd8) begin
          if (state_q == ROW) begin
            wt_in = tile_buf[cyc_q[2:0]];
          end else begin
            for (int k = 0; k < 8; k++) begin
              wt_in[8*k +: 8] = tile_buf[k][{cyc_q[2:0], 3'b000} +: 8];
            end
          end
        end
        if (cyc_q >= LAT_C) begin
          row_we = (state_q == ROW);
          col_we = (state_q == COL);
        end
        if (cyc_q == LAST_C) begin
          state_d = (state_q == ROW) ? COL : OUT;
          cyc_d   = 4'd0;
        end else begin
          cyc_d = cyc_q + 4'd1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        out_row   = tile_buf[idx_q];
        if (out_ready) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = LOAD;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Tile storage: bytes are only moved, never modified; no reset needed.
  always_ff @(posedge clk) begin
    if (load_we) begin
      tile_buf[idx_q] <= in_row;
    end
    if (row_we) begin
      tile_buf[wb_idx] <= wt_out;
    end
    if (col_we) begin
      for (int k = 0; k < 8; k++) begin
        tile_buf[k][{wb_idx, 3'b000} +: 8] <= wt_out[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dwt2d_tile_ctrl.sv
module tb_dwt2d_tile_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_row;
  int          sel;
  bit          mode;  // 0: identity core, 1: byte-reverse core

  logic        ir1, ov1, bz1, td1, ir3, ov3, bz3, td3;
  logic [63:0] wi1, wo1, or1, wi3, wo3, or3;
  logic        in_ready, out_valid, busy, tile_done;
  logic [63:0] wt_in, out_row;

  dwt2d_tile_ctrl #(.LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(ir1),
    .in_row(in_row), .wt_in(wi1), .wt_out(wo1), .out_valid(ov1),
    .out_ready(out_ready), .out_row(or1), .busy(bz1), .tile_done(td1));

  dwt2d_tile_ctrl #(.LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(ir3),
    .in_row(in_row), .wt_in(wi3), .wt_out(wo3), .out_valid(ov3),
    .out_ready(out_ready), .out_row(or3), .busy(bz3), .tile_done(td3));

  assign in_ready  = (sel == 0) ? ir1 : ir3;
  assign out_valid = (sel == 0) ? ov1 : ov3;
  assign busy      = (sel == 0) ? bz1 : bz3;
  assign tile_done = (sel == 0) ? td1 : td3;
  assign wt_in     = (sel == 0) ? wi1 : wi3;
  assign out_row   = (sel == 0) ? or1 : or3;

  // Behavioural 1-D core: transform applied on issue, then a plain delay line.
  function automatic logic [63:0] xf(input logic [63:0] v);
    logic [63:0] o;
    for (int k = 0; k < 8; k++) o[8*k +: 8] = mode ? v[8*(7-k) +: 8] : v[8*k +: 8];
    return o;
  endfunction

  logic [63:0] p1;
  logic [63:0] p3 [3];
  always @(posedge clk) begin
    p1    <= xf(wi1);
    p3[0] <= xf(wi3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign wo1 = p1;
  assign wo3 = p3[2];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [63:0] rows [8];
  logic [63:0] nrows [8];
  int pre_acc = 0;
  int pre_first = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (LAT=%0d cyc=%0d): got %h expected %h", tag, sel ? 3 : 1, cyc, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    #1;
  endtask

  // Reference result: a row pass then a column pass of the chosen core.
  // Identity leaves the tile unchanged; reversal flips both axes.
  function automatic logic [63:0] model_row(input int r);
    logic [63:0] v;
    for (int c = 0; c < 8; c++)
      v[8*c +: 8] = mode ? rows[7-r][8*(7-c) +: 8] : rows[r][8*c +: 8];
    return v;
  endfunction

  // Column 0 as presented to the core: first byte of each row after the row pass.
  function automatic logic [63:0] model_col0();
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mode ? rows[k][63:56] : rows[k][7:0];
    return v;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_tile_done", {63'd0, tile_done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wt_in", wt_in, 64'd0);
  endtask

  // One tile: load (optionally with gaps / held valid), watch the compute
  // phases, drain with an optional stall on row 3. abort_g >= 0 pulses reset
  // at that compute cycle and abandons the tile.
  task automatic tile(input bit hold, input bit gaps, input int stall, input int abort_g, input bit chain);
    int acc, first, last, g, got, stalled, budget, lat;
    logic [63:0] expv [8];
    logic [63:0] c0;
    lat = sel ? 3 : 1;
    for (int r = 0; r < 8; r++) expv[r] = model_row(r);
    c0 = model_col0();
    acc = pre_acc;
    first = pre_first;
    last = pre_first;
    pre_acc = 0;
    budget = 0;
    while (acc < 8 && budget < 200) begin
      step();
      chk("load_no_done", {63'd0, tile_done}, 64'd0);
      in_valid = hold ? 1'b1 : (gaps ? 1'($urandom_range(0, 1)) : 1'b1);
      in_row = rows[acc];
      if (in_valid && in_ready) begin
        if (acc == 0) first = cyc;
        last = cyc;
        acc++;
      end
      budget++;
    end
    chk("load_count", 64'(acc), 64'd8);
    g = 0;
    budget = 0;
    while (budget < 100) begin
      step();
      if (out_valid) break;
      chk("compute_in_ready", {63'd0, in_ready}, 64'd0);
      if (g == 0) begin
        chk("compute_busy", {63'd0, busy}, 64'd1);
        chk("row0_issue", wt_in, rows[0]);
      end
      if (g == 8) chk("row_tail_zero", wt_in, 64'd0);
      if (g == 8 + lat) chk("col0_issue", wt_in, c0);
      if (g == abort_g) begin
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        return;
      end
      in_valid = hold;
      in_row = {$urandom, $urandom};
      g++;
      budget++;
    end
    chk("compute_len", 64'(g), 64'(2 * (8 + lat)));
    got = 0;
    stalled = 0;
    budget = 0;
    while (got < 8 && budget < 100) begin
      chk("out_valid", {63'd0, out_valid}, 64'd1);
      chk("out_in_ready", {63'd0, in_ready}, 64'd0);
      chk("out_no_done", {63'd0, tile_done}, 64'd0);
      chk("out_row", out_row, expv[got]);
      out_ready = !(got == 3 && stalled < stall);
      if (!out_ready) stalled++;
      in_valid = hold;
      if (out_ready) got++;
      budget++;
      if (got < 8) step();
    end
    step();
    out_ready = 1'b1;
    chk("tile_done", {63'd0, tile_done}, 64'd1);
    chk("done_after_last_in", 64'(cyc - last), 64'(2 * (8 + lat) + 9 + stall));
    if (!gaps) chk("tile_period", 64'(cyc - first), 64'(2 * (8 + lat) + 16 + stall));
    chk("back_in_load", {63'd0, in_ready}, 64'd1);
    in_valid = chain;
    in_row = nrows[0];
    if (chain && in_ready) begin
      pre_acc = 1;
      pre_first = cyc;
    end
  endtask

  task automatic rand_rows();
    for (int r = 0; r < 8; r++) rows[r] = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_row = 64'd0;
    out_ready = 1'b1;
    sel = 0;
    mode = 1'b0;
    for (int s = 0; s < 2; s++) begin
      sel = s;
      rst_n = 1'b0;
      step();
      step();
      chk_reset_outputs();
      rst_n = 1'b1;

      mode = 1'b0;
      for (int r = 0; r < 8; r++) rows[r] = 64'h0706050403020100 + 64'(r) * 64'h0808080808080808;
      tile(0, 0, 0, -1, 0);

      mode = 1'b1;
      tile(0, 0, 0, -1, 0);

      mode = 1'($urandom_range(0, 1));
      rand_rows();
      tile(0, 1, 5, -1, 0);

      mode = 1'b1;
      rand_rows();
      for (int r = 0; r < 8; r++) nrows[r] = {$urandom, $urandom};
      tile(1, 0, 0, -1, 1);
      for (int r = 0; r < 8; r++) rows[r] = nrows[r];
      tile(1, 0, 0, -1, 0);

      mode = 1'b0;
      rand_rows();
      tile(0, 0, 0, 8 + (s ? 3 : 1) + 4, 0);
      mode = 1'b1;
      rand_rows();
      tile(0, 0, 0, -1, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
